// File: rtl/ps2_codes_pkg.sv
// Shared constants, state encoding and event layout for the PS/2 Set-2 scancode decoder.
package ps2_codes_pkg;

    localparam logic [7:0] SC_E0          = 8'hE0;
    localparam logic [7:0] SC_F0          = 8'hF0;
    localparam logic [7:0] SC_E1          = 8'hE1;
    localparam logic [7:0] SC_FAKE_LSHIFT = 8'h12;
    localparam logic [7:0] SC_FAKE_RSHIFT = 8'h59;

    localparam logic [7:0] SC_CTRL_AA = 8'hAA;
    localparam logic [7:0] SC_CTRL_FA = 8'hFA;
    localparam logic [7:0] SC_CTRL_FE = 8'hFE;
    localparam logic [7:0] SC_CTRL_EE = 8'hEE;
    localparam logic [7:0] SC_CTRL_00 = 8'h00;
    localparam logic [7:0] SC_CTRL_FF = 8'hFF;

    localparam int PAUSE_LEN = 8;
    localparam int SKIP_W    = $clog2(PAUSE_LEN);
    localparam int EVT_W     = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_E0    = 3'd1,
        ST_F0    = 3'd2,
        ST_E0F0  = 3'd3,
        ST_PAUSE = 3'd4
    } dec_state_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } evt_t;

    function automatic logic is_ctrl(input logic [7:0] b);
        return (b == SC_CTRL_AA) || (b == SC_CTRL_FA) || (b == SC_CTRL_FE) ||
               (b == SC_CTRL_EE) || (b == SC_CTRL_00) || (b == SC_CTRL_FF);
    endfunction

    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == SC_FAKE_LSHIFT) || (b == SC_FAKE_RSHIFT);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO of decoded key events; head entry is read combinationally.
module ps2_event_fifo
    import ps2_codes_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int W     = EVT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, rptr_q;
    logic         wr_en, rd_en;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // A pop frees the slot being written, so a push while full is legal when paired with a pop.
    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (rd_en) rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Turns the PS/2 byte stream into make/break key events, buffered behind a valid/ready FIFO.
module ps2_scancode_decoder
    import ps2_codes_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_extended,
    output logic       evt_released,
    output logic       overflow,
    output logic       ctrl_seen
);

    dec_state_t        state_q, state_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic              ctrl_q, ctrl_d;
    logic              ovf_q;
    logic              push, pop, full, empty;
    evt_t              push_evt, head;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
            ctrl_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            ctrl_q  <= ctrl_d;
            if (push && full && !pop) ovf_q <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        ctrl_d   = 1'b0;
        push     = 1'b0;
        push_evt = '0;
        if (received_data_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (received_data == SC_E0) begin
                        state_d = ST_E0;
                    end else if (received_data == SC_F0) begin
                        state_d = ST_F0;
                    end else if (received_data == SC_E1) begin
                        state_d = ST_PAUSE;
                        skip_d  = SKIP_W'(PAUSE_LEN - 1);
                    end else if (is_ctrl(received_data)) begin
                        ctrl_d = 1'b1;
                    end else begin
                        push     = 1'b1;
                        push_evt = '{ext: 1'b0, rel: 1'b0, code: received_data};
                    end
                end
                ST_E0: begin
                    if (received_data == SC_F0) begin
                        state_d = ST_E0F0;
                    end else if (is_fake_shift(received_data)) begin
                        state_d = ST_IDLE;
                    end else if (received_data != SC_E0) begin
                        state_d  = ST_IDLE;
                        push     = 1'b1;
                        push_evt = '{ext: 1'b1, rel: 1'b0, code: received_data};
                    end
                end
                ST_F0: begin
                    // A second prefix after F0 is malformed; drop the whole sequence.
                    state_d = ST_IDLE;
                    if (received_data != SC_E0 && received_data != SC_F0) begin
                        push     = 1'b1;
                        push_evt = '{ext: 1'b0, rel: 1'b1, code: received_data};
                    end
                end
                ST_E0F0: begin
                    state_d = ST_IDLE;
                    if (!is_fake_shift(received_data)) begin
                        push     = 1'b1;
                        push_evt = '{ext: 1'b1, rel: 1'b1, code: received_data};
                    end
                end
                ST_PAUSE: begin
                    skip_d = skip_q - 1'b1;
                    if (skip_q <= SKIP_W'(1)) begin
                        state_d  = ST_IDLE;
                        skip_d   = '0;
                        push     = 1'b1;
                        push_evt = '{ext: 1'b1, rel: 1'b0, code: SC_E1};
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign evt_valid = !empty;
    assign pop       = evt_valid && evt_ready;

    ps2_event_fifo #(
        .DEPTH(FIFO_DEPTH),
        .AW   (FIFO_AW),
        .W    (EVT_W)
    ) u_fifo (
        .clk_i  (CLOCK_50),
        .rst_i  (reset),
        .push_i (push),
        .pop_i  (pop),
        .wdata_i(push_evt),
        .rdata_o(head),
        .full_o (full),
        .empty_o(empty)
    );

    // Head fields are masked while empty so idle outputs read as zero.
    assign evt_code     = evt_valid ? head.code : 8'h00;
    assign evt_extended = evt_valid && head.ext;
    assign evt_released = evt_valid && head.rel;
    assign overflow     = ovf_q;
    assign ctrl_seen    = ctrl_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Randomised scoreboard bench: a sequence-level reference model issues expected events, a monitor checks them.
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] received_data = 8'h00;
    logic       received_data_en = 1'b0;
    logic       evt_valid, evt_ready = 1'b0;
    logic [7:0] evt_code;
    logic       evt_extended, evt_released, overflow, ctrl_seen;

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .FIFO_AW(2)) dut (
        .CLOCK_50        (clk),
        .reset           (reset),
        .received_data   (received_data),
        .received_data_en(received_data_en),
        .evt_valid       (evt_valid),
        .evt_ready       (evt_ready),
        .evt_code        (evt_code),
        .evt_extended    (evt_extended),
        .evt_released    (evt_released),
        .overflow        (overflow),
        .ctrl_seen       (ctrl_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        bit         ext;
        bit         rel;
    } ev_t;

    int   n_chk = 0;
    int   n_fail = 0;
    ev_t  iss_q[$];
    ev_t  mq[$];
    logic [7:0] sbuf[$];
    bit   ctrl_iss = 0;
    bit   ctrl_prev = 0;
    bit   exp_ovf = 0;
    bit   rst_d = 0;
    int   rdy_mode = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ctrl_byte(input logic [7:0] b);
        return b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'h00 || b == 8'hFF;
    endfunction

    // Sequence view: accumulate bytes until the buffer forms a complete key sequence, then classify it.
    task automatic model_byte(input logic [7:0] b);
        bit prior_all_e0, ext, rel;
        ev_t e;
        sbuf.push_back(b);
        if (sbuf[0] == 8'hE1) begin
            if (sbuf.size() == 8) begin
                e.code = 8'hE1; e.ext = 1; e.rel = 0;
                iss_q.push_back(e);
                sbuf.delete();
            end
            return;
        end
        prior_all_e0 = 1; ext = 0; rel = 0;
        for (int i = 0; i < sbuf.size() - 1; i++) begin
            if (sbuf[i] != 8'hE0) prior_all_e0 = 0;
            if (sbuf[i] == 8'hE0) ext = 1;
            if (sbuf[i] == 8'hF0) rel = 1;
        end
        if ((b == 8'hE0 || b == 8'hF0) && prior_all_e0) return;
        if (!ext && rel && (b == 8'hE0 || b == 8'hF0)) begin
        end else if (ext && (b == 8'h12 || b == 8'h59)) begin
        end else if (!ext && !rel && ctrl_byte(b)) begin
            ctrl_iss = 1;
        end else begin
            e.code = b; e.ext = ext; e.rel = rel;
            iss_q.push_back(e);
        end
        sbuf.delete();
    endtask

    task automatic send(input logic [7:0] b);
        received_data = b;
        received_data_en = 1'b1;
        model_byte(b);
        @(posedge clk); #1;
        received_data_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        sbuf.delete();
        idle(n);
        reset = 1'b0;
    endtask

    initial forever begin
        @(posedge clk); #2;
        case (rdy_mode)
            0: evt_ready = 1'b0;
            1: evt_ready = 1'b1;
            default: evt_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: owns the FIFO-occupancy model and compares every cycle at the falling edge.
    initial forever begin
        int  sz;
        bit  popped;
        ev_t e;
        @(negedge clk);
        if (reset) begin
            if (rst_d) begin
                chk("rst_valid", evt_valid, 0);
                chk("rst_code", evt_code, 0);
                chk("rst_ext", evt_extended, 0);
                chk("rst_rel", evt_released, 0);
                chk("rst_ovf", overflow, 0);
                chk("rst_ctrl", ctrl_seen, 0);
            end
            mq.delete(); iss_q.delete();
            ctrl_iss = 0; ctrl_prev = 0; exp_ovf = 0;
            rst_d = 1;
        end else begin
            rst_d = 0;
            sz = mq.size();
            chk("valid", evt_valid, sz != 0);
            if (sz != 0) begin
                chk("code", evt_code, mq[0].code);
                chk("ext", evt_extended, mq[0].ext);
                chk("rel", evt_released, mq[0].rel);
            end
            chk("overflow", overflow, exp_ovf);
            chk("ctrl_seen", ctrl_seen, ctrl_prev);
            popped = (sz != 0) && evt_ready;
            if (popped) void'(mq.pop_front());
            if (iss_q.size() != 0) begin
                e = iss_q.pop_front();
                if (sz == DEPTH && !popped) exp_ovf = 1;
                else mq.push_back(e);
            end
            ctrl_prev = ctrl_iss;
            ctrl_iss = 0;
        end
    end

    initial begin
        logic [7:0] ctl [6];
        logic [7:0] b;
        int r;
        ctl[0] = 8'hAA; ctl[1] = 8'hFA; ctl[2] = 8'hFE;
        ctl[3] = 8'hEE; ctl[4] = 8'h00; ctl[5] = 8'hFF;

        idle(3);
        reset = 1'b0;
        idle(2);

        rdy_mode = 1;
        send(8'h1C); idle(3);
        send(8'hF0); send(8'h1C); idle(3);
        send(8'hE0); send(8'h75); idle(2);
        send(8'hE0); send(8'hF0); send(8'h75); idle(2);
        send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C); idle(2);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); idle(2);
        send(8'h29); idle(2);
        send(8'hAA); idle(2); send(8'hFA); idle(3);

        // Fill with the consumer stalled, then push and pop together while full.
        rdy_mode = 0; idle(1);
        send(8'h15); send(8'h16); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
        idle(3);
        chk("ovf_after_drop", overflow, 1);
        rdy_mode = 1;
        send(8'h35);
        rdy_mode = 0;
        idle(3);
        chk("full_after_pushpop", mq.size(), DEPTH);
        rdy_mode = 1; idle(8);

        send(8'hE0); idle(1);
        do_reset(2);
        idle(1);
        send(8'h1C); idle(3);

        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 31);
            if (r < 4) b = 8'hE0;
            else if (r < 7) b = 8'hF0;
            else if (r == 7) b = 8'hE1;
            else if (r == 8) b = 8'h12;
            else if (r == 9) b = 8'h59;
            else if (r < 12) b = ctl[$urandom_range(0, 5)];
            else b = 8'($urandom_range(0, 255));
            send(b);
            idle($urandom_range(0, 2));
        end

        rdy_mode = 1;
        idle(20);
        chk("drain_empty", mq.size(), 0);
        chk("drain_valid", evt_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Converts the raw byte stream produced by the PS/2 controller (`received_data` / `received_data_en`) into complete Set-2 key events: make or break, normal or extended. Sits directly downstream of the PS/2 controller and upstream of game input logic such as the hit, stand and deal handlers. Prefix bytes E0 and F0 are absorbed, the 8-byte Pause sequence collapses into one event, and controller/status bytes are discarded. Events are buffered in a small FIFO with a valid/ready handshake, so consumers never miss a key.

## Interface
- `FIFO_DEPTH`, default 4: event FIFO entries; must be a power of two, ≥2.
- `FIFO_AW`, default 2: log2(`FIFO_DEPTH`).

Ports:
- `CLOCK_50`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `received_data`  in  8  byte from the PS/2 controller; valid only while `received_data_en`=1.
- `received_data_en`  in  1  one-cycle strobe per received byte.
- `evt_valid`  out  1  FIFO non-empty; head event presented.
- `evt_ready`  in  1  consumer accepts the head event when `evt_valid`&`evt_ready`.
- `evt_code`  out  8  final scancode byte of the head event.
- `evt_extended`  out  1  head event was E0-prefixed, or is Pause.
- `evt_released`  out  1  head event is a break (F0-prefixed).
- `overflow`  out  1  sticky; set when an event is dropped because the FIFO is full.
- `ctrl_seen`  out  1  one-cycle pulse when a control byte (AA, FA, FE, EE, 00, FF) is discarded in IDLE.

## Operation
- FSM states: IDLE, E0, F0, E0F0, PAUSE. A byte is consumed only on a cycle with `received_data_en`=1. No state changes on other cycles.
- IDLE:
  - E0 → E0.
  - F0 → F0.
  - E1 → PAUSE, with `skip_cnt`=7.
  - Control byte → stay in IDLE and pulse `ctrl_seen`.
  - Any other byte → push {ext=0, rel=0, code}.
- E0:
  - F0 → E0F0.
  - 12 or 59 (fake-shift) → IDLE, no push.
  - E0 → stay in E0.
  - Any other byte → push {1, 0, code} and go to IDLE.
- F0: any byte except E0/F0 → push {0, 1, code} and go to IDLE. E0 or F0 here is a protocol error → IDLE, no push.
- E0F0:
  - 12 or 59 → IDLE, no push.
  - Any other byte → push {1, 1, code} and go to IDLE.
- PAUSE: each byte decrements `skip_cnt`. The byte that brings it from 1 to 0 pushes {1, 0, 8'hE1} and returns to IDLE. Pause never produces a break event.
- FIFO:
  - Write when push and not full.
  - Read when `evt_valid`&`evt_ready`.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full; occupancy is unchanged.
  - Push while full with no pop: the event is dropped and `overflow` is set. `overflow` clears only on `reset`.
- Read/write pointers are `FIFO_AW`+1 bits and wrap naturally. Full = MSBs differ and LSBs equal; empty = pointers equal.
- Reset mid-sequence, e.g. after E0: the FSM returns to IDLE and the partial prefix is discarded.

## Timing
- Reset values: `evt_valid`=0, `evt_code`=0, `evt_extended`=0, `evt_released`=0, `overflow`=0, `ctrl_seen`=0; FSM=IDLE; `skip_cnt`=0; FIFO empty.
- Push is combinational in the cycle of the final byte's strobe, so the event is written at the end of that cycle (cycle N).
  - `evt_valid` rises in cycle N+1; latency is 1 cycle.
- `evt_code`, `evt_extended` and `evt_released` are driven combinationally from the head entry. They are stable while `evt_valid`=1 and `evt_ready`=0.
- After a pop, the next entry is presented the following cycle; `evt_valid` stays high if entries remain.
- `overflow` sets in the cycle after the dropped push.
- `ctrl_seen` is registered: it is high in the cycle after the strobe.
- Strobes arrive at most once per ~2.2k cycles. Back-to-back strobes (one per cycle) must nevertheless be handled correctly.

## Structure
- Package `ps2_codes_pkg`:
  - Byte constants: SC_E0, SC_F0, SC_E1, SC_FAKE_LSHIFT=12, SC_FAKE_RSHIFT=59, and the control bytes AA, FA, FE, EE, 00, FF.
  - PAUSE_LEN=8.
  - FSM state encodings.
  - Event width EVT_W=10.
- Sub-module `ps2_event_fifo`: a parameterised synchronous FIFO of EVT_W-bit entries with push/pop/full/empty. The decoder instantiates one.

## Test plan
- Byte 1C → one event {code=1C, ext=0, rel=0}, `evt_valid` one cycle after the strobe. Bytes F0,1C → {1C, 0, 1}.
- Bytes E0,75 then E0,F0,75 → {75, 1, 0} then {75, 1, 1}. Bytes E0,12,E0,7C → exactly one event, {7C, 1, 0}.
- Bytes E1,14,77,E1,F0,14,F0,77 → exactly one event, {E1, 1, 0}. A following byte 29 → {29, 0, 0}.
- Bytes AA and FA in IDLE → no events and two `ctrl_seen` pulses.
- `evt_ready`=0 while 6 make codes are sent with `FIFO_DEPTH`=4:
  - first 4 events retained in order;
  - `overflow`=1 after the 5th is dropped.
  - Then push and pop in the same cycle while full → count stays 4 and `overflow` is not re-triggered by that push.
- E0 sent, then `reset` pulsed, then 1C → single event {1C, 0, 0}. All outputs are at their reset values during `reset`.
